// File: rtl/irq_arbiter_16.sv
`default_nettype none
// ============================================================================
// Module   : irq_arbiter_16
// Purpose  : Collects 16 asynchronous interrupt request lines, synchronises
//            them, tracks per-source pending state (level or rising-edge
//            triggered) and offers one winning 4-bit source ID at a time
//            over a valid/ack handshake. The consumer feeds the accepted ID
//            into a 4-to-16 decoder to form its one-hot acknowledge.
// Ports    : clock   - system clock, rising edge
//            reset_n - asynchronous active-low reset
//            irq     - raw interrupt requests (asynchronous to clock)
//            mask    - per-source enable, 1 = may be offered
//            id      - offered source ID, stable while valid=1
//            valid   - id is a live offer
//            ack     - consumer accepts id (ignored while valid=0)
//            pending - registered pending vector, before masking
// Params   : SYNC_STAGES - synchroniser depth per line (2..3)
//            EDGE_MASK   - per-source trigger type, 1 = rising edge, 0 = level
// Config   : IRQ_ROUND_ROBIN_EN - when defined, round-robin arbitration
//            starting after the last accepted ID; otherwise fixed priority
//            with the lowest eligible index winning.
// Revision : 1.0 - initial release
// ============================================================================
module irq_arbiter_16 #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [15:0] EDGE_MASK   = 16'h0000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [15:0] irq,
  input  logic [15:0] mask,
  output logic [3:0]  id,
  output logic        valid,
  input  logic        ack,
  output logic [15:0] pending
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_OFFER = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Synchroniser chains
  // --------------------------------------------------------------------------
  logic [15:0] sync_q [SYNC_STAGES];
  logic [15:0] sync_d [SYNC_STAGES];
  logic [15:0] s;
  logic [15:0] s_d_q;

  always_comb begin
    sync_d[0] = irq;
    for (int k = 1; k < SYNC_STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
      s_d_q <= '0;
    end else begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_d[k];
      end
      s_d_q <= s;
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  state_t      state_q, state_d;
  logic [3:0]  id_q, id_d;
  logic        valid_q, valid_d;
  logic [15:0] pending_q, pending_d;
  logic        accept;
  logic [15:0] elig;
  logic [3:0]  winner;

  assign elig = pending_q & mask;

  // --------------------------------------------------------------------------
  // Winner selection
  // --------------------------------------------------------------------------
`ifdef IRQ_ROUND_ROBIN_EN
  logic [3:0] rr_last_q, rr_last_d;
  logic [3:0] cand;
  logic       found;

  // Scan starts one past the last accepted ID; 4-bit arithmetic wraps
  // naturally so the candidate is always a legal index.
  always_comb begin
    winner = 4'd0;
    found  = 1'b0;
    cand   = 4'd0;
    for (int k = 0; k < 16; k++) begin
      cand = rr_last_q + 4'd1 + 4'(k);
      if (!found && elig[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    rr_last_d = accept ? id_q : rr_last_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr_last_q <= 4'hF;
    end else begin
      rr_last_q <= rr_last_d;
    end
  end
`else
  // Descending scan so the lowest set index is the last one written.
  always_comb begin
    winner = 4'd0;
    for (int k = 15; k >= 0; k--) begin
      if (elig[k]) begin
        winner = 4'(k);
      end
    end
  end
`endif

  // --------------------------------------------------------------------------
  // Offer FSM
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    valid_d = valid_q;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|elig) begin
          id_d    = winner;
          valid_d = 1'b1;
          state_d = S_OFFER;
        end
      end
      S_OFFER: begin
        // The offer is frozen here: mask/pending changes cannot retract it.
        if (ack) begin
          accept  = 1'b1;
          valid_d = 1'b0;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        // One dead cycle so a level source that the consumer has just
        // serviced can drop before it is arbitrated again.
        state_d = S_IDLE;
      end
      default: begin
        valid_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Pending update
  // --------------------------------------------------------------------------
  logic [15:0] rise;
  logic [15:0] clr;

  always_comb begin
    rise = s & ~s_d_q;
    clr  = accept ? (16'd1 << id_q) : 16'd0;
    for (int i = 0; i < 16; i++) begin
      if (EDGE_MASK[i]) begin
        // A new edge arriving with the ack of the same source survives.
        pending_d[i] = rise[i] | (pending_q[i] & ~clr[i]);
      end else begin
        pending_d[i] = s[i];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      id_q      <= 4'd0;
      valid_q   <= 1'b0;
      pending_q <= 16'd0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      valid_q   <= valid_d;
      pending_q <= pending_d;
    end
  end

  assign id      = id_q;
  assign valid   = valid_q;
  assign pending = pending_q;

endmodule
`default_nettype wire

// File: tb/tb_irq_arbiter_16.sv
`default_nettype none
// ============================================================================
// Module   : tb_irq_arbiter_16
// Purpose  : Self-checking bench for irq_arbiter_16. A behavioural model
//            predicts pending state and each offered ID; predicted IDs are
//            queued and a monitor pops and compares them when the DUT raises
//            valid. Directed scenarios are followed by randomised traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_irq_arbiter_16;

  localparam int          SYNC  = 2;
  localparam logic [15:0] EMASK = 16'hC288; // edge sources 3,7,9,14,15

  logic        clock   = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] irq     = 16'd0;
  logic [15:0] mask    = 16'd0;
  logic        ack     = 1'b0;
  logic [3:0]  id;
  logic        valid;
  logic [15:0] pending;

  always #5 clock = ~clock;

  irq_arbiter_16 #(
    .SYNC_STAGES (SYNC),
    .EDGE_MASK   (EMASK)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .irq     (irq),
    .mask    (mask),
    .id      (id),
    .valid   (valid),
    .ack     (ack),
    .pending (pending)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: irq history, pending array, offer bookkeeping
  // --------------------------------------------------------------------------
  logic [15:0] hist [0:SYNC];   // hist[k] = irq value sampled k+1 edges ago
  logic [15:0] m_pend;
  bit          m_offering;
  int          m_gap;
  int          m_id;
`ifdef IRQ_ROUND_ROBIN_EN
  int          m_last;
`endif
  int          exp_q[$];

  function automatic int pick(input logic [15:0] el, input int start);
    for (int k = 0; k < 16; k++) begin
      int c;
      c = (start + k) % 16;
      if (el[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k <= SYNC; k++) hist[k] = 16'd0;
    m_pend     = 16'd0;
    m_offering = 1'b0;
    m_gap      = 0;
    m_id       = 0;
`ifdef IRQ_ROUND_ROBIN_EN
    m_last     = 15;
`endif
    exp_q.delete();
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clock or negedge reset_n);
      if (!reset_n) begin
        model_reset();
      end else begin : m_step
        logic [15:0] s_now, s_old, el, nxt;
        bit acc;
        s_now = hist[SYNC-1];
        s_old = hist[SYNC];
        el    = m_pend & mask;
        acc   = m_offering && ack;
        nxt   = m_pend;
        for (int i = 0; i < 16; i++) begin
          if (EMASK[i]) begin
            if (s_now[i] && !s_old[i]) nxt[i] = 1'b1;
            else if (acc && m_id == i) nxt[i] = 1'b0;
          end else begin
            nxt[i] = s_now[i];
          end
        end
        if (m_offering) begin
          if (ack) begin
            m_offering = 1'b0;
            m_gap      = 1;
`ifdef IRQ_ROUND_ROBIN_EN
            m_last     = m_id;
`endif
          end
        end else if (m_gap > 0) begin
          m_gap--;
        end else if (el != 16'd0) begin
`ifdef IRQ_ROUND_ROBIN_EN
          m_id = pick(el, (m_last + 1) % 16);
`else
          m_id = pick(el, 0);
`endif
          m_offering = 1'b1;
          exp_q.push_back(m_id);
        end
        m_pend = nxt;
        for (int k = SYNC; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = irq;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Monitor
  // --------------------------------------------------------------------------
  initial begin
    logic prev_valid;
    int   cur_exp;
    prev_valid = 1'b0;
    cur_exp    = 0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        check("reset_id", 32'(id), 32'd0);
        check("reset_valid", 32'(valid), 32'd0);
        check("reset_pending", 32'(pending), 32'd0);
        prev_valid = 1'b0;
      end else begin
        check("valid", 32'(valid), 32'(m_offering));
        check("pending", 32'(pending), 32'(m_pend));
        if (valid && !prev_valid) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL offer_unexpected actual_id=%0d expected=none at %0t", id, $time);
          end else begin
            cur_exp = exp_q.pop_front();
            if (32'(id) !== 32'(cur_exp)) begin
              n_errors++;
              $display("FAIL offer_id actual=%0d expected=%0d at %0t", id, cur_exp, $time);
            end
          end
        end else if (valid) begin
          check("id_stable", 32'(id), 32'(cur_exp));
        end
        prev_valid = valid;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic step();
    @(negedge clock);
    #2;
  endtask

  task automatic do_reset();
    ack     = 1'b0;
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic drain(input int n);
    ack = 1'b1;
    repeat (n) step();
    ack = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int t;
    t = 0;
    while (!valid && t < 40) begin
      step();
      t++;
    end
    if (!valid) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s timeout actual_valid=%0b expected=1", name, valid);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------------------
  // Scenarios
  // --------------------------------------------------------------------------
  initial begin
    int got[4];
    int exp6[4];

    // Reset held with every line asserted, then released.
    reset_n = 1'b0;
    irq     = 16'hFFFF;
    mask    = 16'hFFFF;
    repeat (6) step();
    reset_n = 1'b1;
    repeat (10) step();
    irq = 16'd0;
    drain(60);

    // Level source 5: offered on the 4th edge, re-offered after a 2-cycle gap.
    do_reset();
    irq = 16'h0020;
    repeat (3) step();
    check("lat_before", 32'(valid), 32'd0);
    step();
    check("lat_valid", 32'(valid), 32'd1);
    check("lat_id", 32'(id), 32'd5);
    ack = 1'b1;
    step();
    ack = 1'b0;
    check("gap1", 32'(valid), 32'd0);
    step();
    check("gap2", 32'(valid), 32'd0);
    step();
    check("reoffer_valid", 32'(valid), 32'd1);
    check("reoffer_id", 32'(id), 32'd5);
    irq = 16'd0;
    drain(20);

    // Edge sources 3 and 9 pulsed together.
    do_reset();
    irq = 16'h0208;
    step();
    irq = 16'd0;
    wait_valid("edge39_first");
    check("edge39_id3", 32'(id), 32'd3);
    ack = 1'b1;
    step();
    ack = 1'b0;
    check("edge39_pend", 32'(pending), 32'h0200);
    wait_valid("edge39_second");
    check("edge39_id9", 32'(id), 32'd9);
    ack = 1'b1;
    step();
    ack = 1'b0;
    check("edge39_clear", 32'(pending), 32'h0000);
    repeat (4) step();

    // Masked edge source 7 stays pending until enabled.
    mask = 16'hFF7F;
    irq  = 16'h0080;
    step();
    irq = 16'd0;
    repeat (6) step();
    check("mask7_valid", 32'(valid), 32'd0);
    check("mask7_pend", 32'(pending), 32'h0080);
    mask = 16'hFFFF;
    step();
    check("unmask7_valid", 32'(valid), 32'd1);
    check("unmask7_id", 32'(id), 32'd7);
    drain(10);

    // New edge on source 3 coincides with the ack of id 3.
    irq = 16'h0008;
    step();
    irq = 16'd0;
    wait_valid("race3_first");
    check("race3_id", 32'(id), 32'd3);
    irq = 16'h0008;
    repeat (SYNC) step();
    ack = 1'b1;
    step();
    ack = 1'b0;
    irq = 16'd0;
    check("race3_pend", 32'(pending & 16'h0008), 32'h0008);
    wait_valid("race3_again");
    check("race3_reoffer", 32'(id), 32'd3);
    drain(10);

    // Level sources 1 and 2 held, every offer acknowledged.
    do_reset();
    irq = 16'h0006;
`ifdef IRQ_ROUND_ROBIN_EN
    exp6 = '{1, 2, 1, 2};
`else
    exp6 = '{1, 1, 1, 1};
`endif
    for (int k = 0; k < 4; k++) begin
      wait_valid("seq_wait");
      got[k] = int'(id);
      ack = 1'b1;
      step();
      ack = 1'b0;
    end
    for (int k = 0; k < 4; k++) check("seq_id", 32'(got[k]), 32'(exp6[k]));
    irq = 16'd0;
    drain(20);

    // Randomised traffic with occasional mid-run resets.
    for (int n = 0; n < 1500; n++) begin
      irq = irq ^ (16'($urandom) & 16'($urandom) & 16'($urandom));
      if ($urandom_range(0, 49) == 0) mask = 16'($urandom) | 16'($urandom);
      ack = ($urandom_range(0, 3) == 0);
      if (n % 500 == 250) begin
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
      end
      step();
    end
    irq  = 16'd0;
    mask = 16'hFFFF;
    drain(60);
    step();
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
